// File: rtl/phase_adj_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phase_adj_pkg
// Description : Shared definitions for the multi-channel phase adjuster:
//               active-low 7-segment glyphs (bit 6 = g ... bit 0 = a),
//               hex-to-glyph lookup and the last-direction type.
// Revision    : 1.0 - initial release
// ============================================================================
package phase_adj_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] i_val);
    logic [6:0] w_seg;
    case (i_val)
      4'h0:    w_seg = SEG_0;
      4'h1:    w_seg = SEG_1;
      4'h2:    w_seg = SEG_2;
      4'h3:    w_seg = SEG_3;
      4'h4:    w_seg = SEG_4;
      4'h5:    w_seg = SEG_5;
      4'h6:    w_seg = SEG_6;
      4'h7:    w_seg = SEG_7;
      4'h8:    w_seg = SEG_8;
      4'h9:    w_seg = SEG_9;
      4'hA:    w_seg = SEG_A;
      4'hB:    w_seg = SEG_B;
      4'hC:    w_seg = SEG_C;
      4'hD:    w_seg = SEG_D;
      4'hE:    w_seg = SEG_E;
      default: w_seg = SEG_F;
    endcase
    return w_seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_fall_sync.sv
`default_nettype none
// ============================================================================
// Module      : btn_fall_sync
// Description : 2-FF synchroniser for a raw active-low push-button followed by
//               a registered falling-edge detector producing a one-cycle
//               press pulse.
// Ports       : i_clk   - system clock
//               i_rst_n - asynchronous active-low reset
//               i_btn_n - raw active-low button
//               o_press - one-cycle press pulse
// Revision    : 1.0 - initial release
// ============================================================================
module btn_fall_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_press
);

  logic r_s0;
  logic r_s1;
  logic r_prev;
  logic r_v0;
  logic r_v1;
  logic r_armed;
  logic r_press;

  // r_v0/r_v1 track when r_s1 holds a genuinely sampled level rather than its
  // reset value. The detector only arms after a real released level has been
  // seen, so a button held through reset release stays silent until it is
  // released and pressed again.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s0    <= 1'b1;
      r_s1    <= 1'b1;
      r_prev  <= 1'b1;
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
      r_armed <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_s0    <= i_btn_n;
      r_s1    <= r_s0;
      r_prev  <= r_s1;
      r_v0    <= 1'b1;
      r_v1    <= r_v0;
      r_armed <= r_armed | (r_v1 & r_s1);
      r_press <= r_armed & r_prev & ~r_s1;
    end
  end

  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/ctr_phase_adjust_multi.sv
`default_nettype none
// ============================================================================
// Module      : ctr_phase_adjust_multi
// Description : Button-driven phase controller for N_CH wave channels. Four
//               debounced-edge buttons select a channel, cycle a power-of-two
//               step exponent and add/subtract the step from the selected
//               phase register in wrap or saturate mode. Drives three
//               active-low 7-segment status digits.
// Ports       : i_clk, i_rst_n           - clock, async active-low reset
//               i_en                     - 1 = buttons act, 0 = state held
//               i_mode_sat               - 0 = modulo wrap, 1 = saturate
//               i_btn_ch/step/up/dn      - raw active-low buttons
//               o_phase                  - packed phase words
//               o_upd, o_upd_ch          - change pulse, last changed channel
//               o_hex_0/1/2              - channel, exponent, direction digits
// Revision    : 1.0 - initial release
// ============================================================================
module ctr_phase_adjust_multi
  import phase_adj_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int PHASE_W    = 9,
  parameter int STEP_EXP_W = 3,
  parameter int SIZE_SEG   = 7,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic                      i_mode_sat,
  input  logic                      i_btn_ch,
  input  logic                      i_btn_step,
  input  logic                      i_btn_up,
  input  logic                      i_btn_dn,
  output logic [N_CH*PHASE_W-1:0]   o_phase,
  output logic                      o_upd,
  output logic [CH_W-1:0]           o_upd_ch,
  output logic [SIZE_SEG-1:0]       o_hex_0,
  output logic [SIZE_SEG-1:0]       o_hex_1,
  output logic [SIZE_SEG-1:0]       o_hex_2
);

  // Exponent cycles over 0..min(2^STEP_EXP_W, PHASE_W)-1
  localparam int EXP_LIM = ((1 << STEP_EXP_W) < PHASE_W) ? (1 << STEP_EXP_W) : PHASE_W;
  localparam logic [STEP_EXP_W-1:0] EXP_MAX = STEP_EXP_W'(EXP_LIM - 1);
  localparam logic [CH_W-1:0]       CH_MAX  = CH_W'(N_CH - 1);

  // --------------------------------------------------------------------------
  // Button conditioning: index 0 = ch, 1 = step, 2 = up, 3 = dn
  // --------------------------------------------------------------------------
  logic [3:0] w_btn_raw;
  logic [3:0] w_press;
  logic [3:0] w_go;

  assign w_btn_raw = {i_btn_dn, i_btn_up, i_btn_step, i_btn_ch};

  generate
    for (genvar b = 0; b < 4; b++) begin : g_btn
      btn_fall_sync u_btn (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn_n (w_btn_raw[b]),
        .o_press (w_press[b])
      );
    end
  endgenerate

  assign w_go = w_press & {4{i_en}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PHASE_W-1:0]    r_phase [N_CH];
  logic [CH_W-1:0]       r_sel_ch;
  logic [STEP_EXP_W-1:0] r_exp;
  dir_e                  r_dir;
  logic                  r_upd;
  logic [CH_W-1:0]       r_upd_ch;
  logic [SIZE_SEG-1:0]   r_hex_0;
  logic [SIZE_SEG-1:0]   r_hex_1;
  logic [SIZE_SEG-1:0]   r_hex_2;

  // --------------------------------------------------------------------------
  // Shared adder/clamp on the selected channel, carried in PHASE_W+1 bits so
  // the top bit flags overflow (up) or borrow (down).
  // --------------------------------------------------------------------------
  logic                  w_adj;
  logic [PHASE_W-1:0]    w_cur;
  logic [PHASE_W:0]      w_step;
  logic [PHASE_W:0]      w_sum;
  logic [PHASE_W:0]      w_diff;
  logic [PHASE_W-1:0]    w_nxt;
  logic                  w_chg;
  logic [CH_W-1:0]       w_sel_nxt;
  logic [STEP_EXP_W-1:0] w_exp_nxt;
  dir_e                  w_dir_nxt;

  assign w_adj  = w_go[2] ^ w_go[3];
  assign w_cur  = r_phase[r_sel_ch];
  assign w_step = (PHASE_W + 1)'(1) << r_exp;
  assign w_sum  = {1'b0, w_cur} + w_step;
  assign w_diff = {1'b0, w_cur} - w_step;

  always_comb begin
    w_nxt = w_cur;
    if (w_adj) begin
      if (w_go[2]) begin
        w_nxt = (i_mode_sat && w_sum[PHASE_W]) ? {PHASE_W{1'b1}} : w_sum[PHASE_W-1:0];
      end else begin
        w_nxt = (i_mode_sat && w_diff[PHASE_W]) ? {PHASE_W{1'b0}} : w_diff[PHASE_W-1:0];
      end
    end
  end

  // A saturated no-op leaves the stored value alone and raises no pulse
  assign w_chg = w_adj && (w_nxt != w_cur);

  always_comb begin
    w_sel_nxt = r_sel_ch;
    w_exp_nxt = r_exp;
    w_dir_nxt = r_dir;
    if (w_go[0]) begin
      w_sel_nxt = (r_sel_ch == CH_MAX) ? '0 : r_sel_ch + 1'b1;
    end
    if (w_go[1]) begin
      w_exp_nxt = (r_exp == EXP_MAX) ? '0 : r_exp + 1'b1;
    end
    if (w_adj) begin
      w_dir_nxt = w_go[2] ? DIR_UP : DIR_DN;
    end
  end

  // Adjustment always targets the channel/exponent in effect before this
  // cycle's ch/step presses; the new selection takes effect next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        r_phase[c] <= '0;
      end
      r_sel_ch <= '0;
      r_exp    <= '0;
      r_dir    <= DIR_NONE;
      r_upd    <= 1'b0;
      r_upd_ch <= '0;
      r_hex_0  <= SIZE_SEG'(SEG_0);
      r_hex_1  <= SIZE_SEG'(SEG_0);
      r_hex_2  <= SIZE_SEG'(SEG_BLANK);
    end else begin
      if (w_chg) begin
        r_phase[r_sel_ch] <= w_nxt;
        r_upd_ch          <= r_sel_ch;
      end
      r_upd    <= w_chg;
      r_sel_ch <= w_sel_nxt;
      r_exp    <= w_exp_nxt;
      r_dir    <= w_dir_nxt;
      r_hex_0  <= SIZE_SEG'(hex_to_seg(4'(w_sel_nxt)));
      r_hex_1  <= SIZE_SEG'(hex_to_seg(4'(w_exp_nxt)));
      r_hex_2  <= (w_dir_nxt == DIR_DN) ? SIZE_SEG'(SEG_DASH) : SIZE_SEG'(SEG_BLANK);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_pack
      assign o_phase[c*PHASE_W +: PHASE_W] = r_phase[c];
    end
  endgenerate

  assign o_upd    = r_upd;
  assign o_upd_ch = r_upd_ch;
  assign o_hex_0  = r_hex_0;
  assign o_hex_1  = r_hex_1;
  assign o_hex_2  = r_hex_2;

endmodule
`default_nettype wire

// File: tb/tb_ctr_phase_adjust_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctr_phase_adjust_multi
// Description : Self-checking bench for ctr_phase_adjust_multi: directed
//               button sequences plus random presses, compared against a
//               press-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctr_phase_adjust_multi;

  localparam int N_CH       = 4;
  localparam int PHASE_W    = 9;
  localparam int STEP_EXP_W = 3;
  localparam int SIZE_SEG   = 7;
  localparam int CH_W       = 2;
  localparam int PMAX       = (1 << PHASE_W) - 1;
  localparam int EXP_LIM    = 8;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n = 1'b0;
  logic                    i_en = 1'b1;
  logic                    i_mode_sat = 1'b0;
  logic                    i_btn_ch = 1'b1;
  logic                    i_btn_step = 1'b1;
  logic                    i_btn_up = 1'b1;
  logic                    i_btn_dn = 1'b1;
  logic [N_CH*PHASE_W-1:0] o_phase;
  logic                    o_upd;
  logic [CH_W-1:0]         o_upd_ch;
  logic [SIZE_SEG-1:0]     o_hex_0;
  logic [SIZE_SEG-1:0]     o_hex_1;
  logic [SIZE_SEG-1:0]     o_hex_2;

  ctr_phase_adjust_multi #(
    .N_CH       (N_CH),
    .PHASE_W    (PHASE_W),
    .STEP_EXP_W (STEP_EXP_W),
    .SIZE_SEG   (SIZE_SEG)
  ) u_dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_mode_sat (i_mode_sat),
    .i_btn_ch   (i_btn_ch),
    .i_btn_step (i_btn_step),
    .i_btn_up   (i_btn_up),
    .i_btn_dn   (i_btn_dn),
    .o_phase    (o_phase),
    .o_upd      (o_upd),
    .o_upd_ch   (o_upd_ch),
    .o_hex_0    (o_hex_0),
    .o_hex_1    (o_hex_1),
    .o_hex_2    (o_hex_2)
  );

  always #5 i_clk = ~i_clk;

  // Active-low glyphs, bit 6 = g ... bit 0 = a
  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [6:0] G_DASH  = 7'h3F;
  localparam logic [6:0] G_BLANK = 7'h7F;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // o_upd pulse counter
  int upd_total = 0;
  always @(negedge i_clk) if (i_rst_n && o_upd === 1'b1) upd_total++;

  // --------------------------------------------------------------------------
  // Reference model: state updated once per press event
  // --------------------------------------------------------------------------
  int m_ph [N_CH];
  int m_sel, m_exp, m_updch, m_dir;   // m_dir: 0 none, 1 up, 2 down

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) m_ph[c] = 0;
    m_sel = 0; m_exp = 0; m_updch = 0; m_dir = 0;
  endfunction

  // mask bit 0 = ch, 1 = step, 2 = up, 3 = dn; returns expected pulse count
  function automatic int model_apply(input logic [3:0] m);
    int v;
    int chg;
    chg = 0;
    if (!i_en) return 0;
    if (m[2] != m[3]) begin
      if (m[2]) begin
        v = m_ph[m_sel] + (1 << m_exp);
        if (v > PMAX) v = i_mode_sat ? PMAX : v - (PMAX + 1);
      end else begin
        v = m_ph[m_sel] - (1 << m_exp);
        if (v < 0) v = i_mode_sat ? 0 : v + (PMAX + 1);
      end
      if (v != m_ph[m_sel]) begin
        chg = 1;
        m_ph[m_sel] = v;
        m_updch = m_sel;
      end
      m_dir = m[2] ? 1 : 2;
    end
    if (m[0]) m_sel = (m_sel + 1) % N_CH;
    if (m[1]) m_exp = (m_exp + 1) % EXP_LIM;
    return chg;
  endfunction

  task automatic check_all(input string tag);
    logic [N_CH*PHASE_W-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c*PHASE_W +: PHASE_W] = PHASE_W'(m_ph[c]);
    chk({tag, ".phase"}, 64'(o_phase), 64'(v));
    chk({tag, ".upd_ch"}, 64'(o_upd_ch), 64'(m_updch));
    chk({tag, ".hex0"}, 64'(o_hex_0), 64'(seg_tab[m_sel]));
    chk({tag, ".hex1"}, 64'(o_hex_1), 64'(seg_tab[m_exp]));
    chk({tag, ".hex2"}, 64'(o_hex_2), 64'((m_dir == 2) ? G_DASH : G_BLANK));
  endtask

  task automatic set_btns(input logic [3:0] m);
    i_btn_ch   = ~m[0];
    i_btn_step = ~m[1];
    i_btn_up   = ~m[2];
    i_btn_dn   = ~m[3];
  endtask

  task automatic press(input string tag, input logic [3:0] m, input int hold);
    int start;
    int exp_p;
    exp_p = model_apply(m);
    @(posedge i_clk); #1;
    start = upd_total;
    set_btns(m);
    repeat (hold) @(posedge i_clk);
    #1 set_btns(4'h0);
    repeat (6) @(posedge i_clk);
    @(negedge i_clk);
    chk({tag, ".upd_cnt"}, 64'(upd_total - start), 64'(exp_p));
    check_all(tag);
  endtask

  int p;
  int start_cnt;

  initial begin
    model_reset();
    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst.upd", 64'(o_upd), 64'd0);
    check_all("rst");
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    repeat (4) @(posedge i_clk);

    // First press: latency to edge k+3
    @(posedge i_clk); #1 i_btn_up = 1'b0;
    p = model_apply(4'b0100);
    repeat (3) @(posedge i_clk);         // edges k, k+1, k+2
    @(negedge i_clk);
    chk("lat.upd_k2", 64'(o_upd), 64'd0);
    @(posedge i_clk);                    // edge k+3
    @(negedge i_clk);
    chk("lat.upd_k3", 64'(o_upd), 64'(p));
    check_all("lat");
    i_btn_up = 1'b1;
    repeat (4) @(posedge i_clk);

    // Wrap and saturate at zero
    press("up_to_2", 4'b0100, 1);
    press("dn_a", 4'b1000, 2);
    press("dn_b", 4'b1000, 2);
    press("dn_wrap", 4'b1000, 1);
    chk("dn_wrap.ph0", 64'(o_phase[PHASE_W-1:0]), 64'd511);
    press("up_wrap", 4'b0100, 1);
    i_mode_sat = 1'b1;
    press("dn_sat", 4'b1000, 1);
    i_mode_sat = 1'b0;

    // Step x3, ch, up x2 -> phase[1] = 16
    for (int i = 0; i < 3; i++) press("step", 4'b0010, 1);
    press("ch", 4'b0001, 1);
    press("up1", 4'b0100, 2);
    press("up2", 4'b0100, 3);
    chk("ch1.ph1", 64'(o_phase[PHASE_W +: PHASE_W]), 64'd16);

    // Saturate at top on channel 1: step to exp 7 then up several times
    for (int i = 0; i < 4; i++) press("step7", 4'b0010, 1);
    i_mode_sat = 1'b1;
    for (int i = 0; i < 5; i++) press("up_sat", 4'b0100, 1);
    chk("sat.ph1", 64'(o_phase[PHASE_W +: PHASE_W]), 64'(PMAX));
    i_mode_sat = 1'b0;

    // Simultaneous up+dn, then long hold
    press("updn", 4'b1100, 2);
    press("hold100", 4'b0100, 100);

    // Disabled: everything ignored
    i_en = 1'b0;
    press("dis", 4'b1111, 3);
    i_en = 1'b1;

    // Channel and exponent wrap
    for (int i = 0; i < N_CH; i++) press("ch_wrap", 4'b0001, 1);
    for (int i = 0; i < EXP_LIM; i++) press("exp_wrap", 4'b0010, 1);
    // Coincident ch + up uses the old channel
    press("ch_up", 4'b0101, 1);

    // Reset asserted mid-update, button held across release
    @(posedge i_clk); #1 i_btn_up = 1'b0;
    repeat (3) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst.upd", 64'(o_upd), 64'd0);
    check_all("midrst");
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    start_cnt = upd_total;
    repeat (8) @(posedge i_clk);
    #1 i_btn_up = 1'b1;
    repeat (6) @(posedge i_clk);
    @(negedge i_clk);
    chk("held_rst.upd_cnt", 64'(upd_total - start_cnt), 64'd0);
    check_all("held_rst");
    press("after_rst", 4'b0100, 1);

    // Random presses
    for (int i = 0; i < 80; i++) begin
      i_en       = ($urandom_range(0, 7) != 0);
      i_mode_sat = $urandom_range(0, 1);
      press("rnd", 4'($urandom_range(0, 15)), $urandom_range(1, 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ctr_phase_adjust_multi.md
# ctr_phase_adjust_multi

Button-driven phase controller for N independent wave channels, generalising the single-channel phase adjuster to a parametrised channel count and phase width. It adds per-channel phase registers, power-of-two step selection, up/down buttons, and a runtime wrap-or-saturate mode. It sits between the board push-buttons and the per-channel DDS/LUT phase-offset inputs, and drives 7-segment status digits.

## Interface
- N_CH, 4 — number of phase channels, 1..16
- PHASE_W, 9 — phase word width per channel, 4..16
- STEP_EXP_W, 3 — width of step exponent; step = 1 << exp, exp limited to 0..PHASE_W-1
- SIZE_SEG, 7 — 7-segment digit width
- i_clk  in  1  system clock; all logic on its rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_en  in  1  level; 1 = wave mode, buttons act; 0 = buttons ignored, state held
- i_mode_sat  in  1  level; 0 = modulo wrap, 1 = saturate at 0 / 2^PHASE_W-1
- i_btn_ch  in  1  raw active-low button: next channel
- i_btn_step  in  1  raw active-low button: next step exponent
- i_btn_up  in  1  raw active-low button: add step to selected channel
- i_btn_dn  in  1  raw active-low button: subtract step from selected channel
- o_phase  out  N_CH*PHASE_W  packed phase words, channel c at [c*PHASE_W +: PHASE_W]
- o_upd  out  1  one-cycle pulse when any phase register changed
- o_upd_ch  out  $clog2(N_CH) (min 1)  channel index of the last update, held between pulses
- o_hex_0  out  SIZE_SEG  selected channel digit
- o_hex_1  out  SIZE_SEG  step exponent digit
- o_hex_2  out  SIZE_SEG  last direction: '-' for down, blank for up / none

## Operation
- Each raw button: 2-FF synchroniser, then falling-edge detect -> one-cycle press pulse. Held button produces exactly one pulse.
- Press pulses are gated by i_en; with i_en = 0 no register but the synchronisers changes.
- ch pulse: sel_ch <= (sel_ch == N_CH-1) ? 0 : sel_ch+1.
- step pulse: exp <= (exp == min(2^STEP_EXP_W, PHASE_W)-1) ? 0 : exp+1.
- up XOR dn pulse: phase[sel_ch] updated with step = 1 << exp, computed in PHASE_W+1 bits.
  - Wrap mode: result modulo 2^PHASE_W.
  - Saturate mode: up clamps at 2^PHASE_W-1; dn clamps at 0.
  - o_upd pulses only if the stored value actually changed. A saturated no-op gives no pulse.
- Both up and dn pulses in the same cycle: no phase change, no o_upd, direction unchanged.
- ch pulse coincident with up/dn: the adjustment applies to the old sel_ch; the new channel takes effect next cycle. step pulse coincident with up/dn: the old exp is used.
- Non-selected channels never change.
- Segment encoding is active-low (0 = lit). Digits 0-F are in hex.

## Timing
- Reset values: all phases 0, sel_ch 0, exp 0, o_upd 0, o_upd_ch 0, o_hex_0 = '0', o_hex_1 = '0', o_hex_2 = blank.
- Button latency: raw low sampled at edge k -> press pulse high during cycle after edge k+2 -> o_phase, o_upd, o_upd_ch and o_hex_* registered at edge k+3.
- All outputs are registered; no combinational path from inputs to outputs.
- Asserting reset mid-press clears everything immediately. The synchronisers reset to 1 (released), so a button still held across reset release produces no pulse until it is released and pressed again.
- i_mode_sat is sampled in the update cycle; changing it never alters stored phases.

## Structure
- Package phase_adj_pkg holds:
  - SEG_* constants for the active-low 7-segment glyphs 0-F, '-' and blank.
  - function hex_to_seg.
  - typedef dir_e {DIR_NONE, DIR_UP, DIR_DN}.
- Sub-module btn_fall_sync contains the synchroniser and falling-edge pulse, instantiated 4×.
- Phase registers are an N_CH-deep array with one shared adder/clamp on the selected channel.

## Test plan
- Reset, then press up once with i_en = 1 and exp = 0 -> phase[0] = 1, o_upd pulse at edge k+3, o_upd_ch = 0, hex_2 blank.
- PHASE_W = 9, wrap mode, phase[0] = 0, press dn -> phase[0] = 511. Repeat in saturate mode -> phase[0] stays 0 and o_upd does not pulse.
- Press step 3× (exp = 3), then ch once, then up twice -> phase[1] = 16, all other channels 0, hex_0 = '1', hex_1 = '3'.
- Press up and dn on the same cycle -> no change, no o_upd. Hold up for 100 cycles -> exactly one increment.
- i_en = 0, press all buttons -> outputs unchanged. Reset asserted mid-update -> all outputs return to reset values within the same cycle.
- Press ch N_CH times -> sel_ch wraps to 0. Press step past its limit -> exp wraps to 0.
